muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
// Iterative signed MULT/DIV engine that owns the HI/LO registers of the multicycle MIPS core.
// The main control FSM pulses a start and holds in its MULT/DIV state until done.
// MFHI/MFLO read hi_out/lo_out directly.
// Internally: a sequencer FSM, a 6-bit iteration counter, and a shift/add-subtract datapath on operand magnitudes.
// PARAMETERS
// WIDTH     32  operand width; HI/LO are WIDTH bits each
// CNT_W     6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// clk         in   1      rising-edge clock
// reset       in   1      asynchronous, active-high; clears all state
// mult_start  in   1      start signed multiply; sampled only in IDLE
// div_start   in   1      start signed divide; sampled only in IDLE
// op_a        in   WIDTH  rs operand (multiplicand/dividend); sampled with start
// op_b        in   WIDTH  rt operand (multiplier/divisor); sampled with start
// busy        out  1      high from the cycle after start until done
// done        out  1      one-cycle pulse; HI/LO valid in the same cycle
// div_zero    out  1      one-cycle pulse with done when divisor==0
// hi_out      out  WIDTH  HI register
// lo_out      out  WIDTH  LO register
// BEHAVIOUR
// - Reset values: busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, state=IDLE, counter=0.
// - Reset is asynchronous and wins at any point. An in-flight operation is discarded with no done pulse.
// - All outputs are registered.
// - States: IDLE, MUL_RUN, DIV_RUN, FIX, FINISH.
// - IDLE: both starts high -> mult_start wins. On start (edge k), latch |op_a|, |op_b|, result sign, remainder sign (= sign of op_a).
//   Clear the accumulator, counter=0, busy=1.
// - IDLE divide with op_b==0 -> FINISH directly. done and div_zero are high after edge k+1; HI/LO unchanged.
// - MUL_RUN/DIV_RUN: one unsigned shift-add (mult) or restoring shift-subtract (div) step per cycle, WIDTH steps.
//   On the step with counter==WIDTH-1 -> FIX.
// - FIX: apply sign correction and write HI/LO. Multiply: {HI,LO} = 2*WIDTH-bit signed product.
//   Divide: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
//   Then -> FINISH.
// - FINISH: done=1 (and div_zero as applicable) for exactly one cycle, busy=0, then -> IDLE.
// - Latency: start at edge k -> done high after edge k+WIDTH+2 (34 cycles for WIDTH=32).
// - Next start is accepted in the cycle after done.
// - Starts while busy or in FINISH are ignored; no queuing. op_a/op_b may change freely after the start edge.
// - Overflow, 0x80000000 / -1: LO=0x80000000, HI=0 (magnitude wrap, no trap). Multiply never overflows.
// - HI/LO change only in FIX or on reset. They hold across div-by-zero and ignored starts.
// STRUCTURE
// - Shared include muldiv_defs.vh: state encodings (3-bit), WIDTH default, opcode select constants (OP_MULT=0, OP_DIV=1).
//   The main control unit includes it for the handshake.
// - One sub-module muldiv_step: combinational single-iteration unit. Inputs: acc, operand, op select.
//   Outputs: next acc/shift register and the quotient bit.
// - FSM, counter, sign handling, and HI/LO stay in muldiv_sequencer.
// TESTING
// - mult 7 x -3 -> after 34 cycles done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy low same cycle.
// - mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0x00000000.
// - div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 7 / -2 -> LO=0xFFFFFFFD, HI=0x00000001.
// - div 5 / 0 with HI=0x11, LO=0x22 preloaded -> done and div_zero high one cycle after start, HI/LO unchanged.
// - mult_start and div_start high together with 6, 3 -> multiply executes: LO=18, HI=0.
//   A div_start pulsed at cycle 5 of the run is ignored.
// - reset asserted asynchronously at cycle 10 of a divide -> busy, done, HI, LO = 0 immediately.
//   No done pulse follows; a new mult 2 x 3 then gives LO=6.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
// Shared definitions for the HI/LO multiply/divide engine of the multicycle
// MIPS core. The main control unit imports the same package, so the operation
// selects and state encodings stay in step with the handshake it expects.
//   DEFAULT_WIDTH / DEFAULT_CNT_W : default operand and iteration-counter widths
//   OP_MULT / OP_DIV              : operation select seen by the step unit
//   ST_*                          : 3-bit sequencer state encodings
package muldiv_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MUL_RUN = 3'd1;
  localparam logic [2:0] ST_DIV_RUN = 3'd2;
  localparam logic [2:0] ST_FIX     = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

endpackage

// File: rtl/muldiv_sequencer_step.sv
// muldiv_sequencer_step
// Combinational single iteration of the unsigned magnitude datapath.
// The working value is the pair {acc, shreg}.
//   Multiply : shift-add. Adds operand to acc when shreg[0] is set, then
//              shifts {carry, acc, shreg} right by one.
//   Divide   : restoring shift-subtract. Shifts {acc, shreg} left by one and
//              subtracts operand from the partial remainder if it fits.
// Ports:
//   op_sel     in  1      OP_MULT or OP_DIV
//   acc        in  WIDTH  high half (partial product / partial remainder)
//   shreg      in  WIDTH  low half (multiplier / dividend-then-quotient)
//   operand    in  WIDTH  multiplicand magnitude or divisor magnitude
//   acc_next   out WIDTH  next high half
//   shreg_next out WIDTH  next low half; the vacated LSB is left at 0 in divide
//   q_bit      out 1      quotient bit produced this step (0 for multiply)
module muldiv_sequencer_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op_sel,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // The partial remainder is always below the divisor, so the shifted value
  // needs one extra bit and the difference, when taken, fits in WIDTH bits.
  always_comb begin
    addend     = shreg[0] ? operand : '0;
    sum        = {1'b0, acc} + {1'b0, addend};
    rem_sh     = {acc, shreg[WIDTH-1]};
    fits       = (rem_sh >= {1'b0, operand});
    diff       = rem_sh[WIDTH-1:0] - operand;
    acc_next   = acc;
    shreg_next = shreg;
    q_bit      = 1'b0;
    if (op_sel == OP_MULT) begin
      acc_next   = sum[WIDTH:1];
      shreg_next = {sum[0], shreg[WIDTH-1:1]};
    end else begin
      q_bit      = fits;
      acc_next   = fits ? diff : rem_sh[WIDTH-1:0];
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative signed MULT/DIV engine owning the HI/LO registers. Operands are
// reduced to magnitudes at start, WIDTH unsigned steps run through
// muldiv_sequencer_step, and the sign is re-applied in FIX.
// Latency: start sampled at edge k, done high after edge k+WIDTH+2.
// Ports:
//   clk         in  1      rising-edge clock
//   reset       in  1      asynchronous active-high reset
//   mult_start  in  1      start signed multiply (IDLE only, wins over div)
//   div_start   in  1      start signed divide (IDLE only)
//   op_a        in  WIDTH  rs: multiplicand / dividend
//   op_b        in  WIDTH  rt: multiplier / divisor
//   busy        out 1      operation in progress
//   done        out 1      one-cycle completion pulse, HI/LO valid
//   div_zero    out 1      pulses with done when the divisor was zero
//   hi_out      out WIDTH  HI register
//   lo_out      out WIDTH  LO register
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic             op_sel;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] operand;
  logic             res_neg;
  logic             rem_neg;
  logic             dz_pend;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_shreg;
  logic               step_q;
  logic               last_step;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes of the incoming operands. The most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b = op_b[WIDTH-1] ? -op_b : op_b;
  end

  // Sign correction applied in FIX. The quotient takes the product sign and
  // the remainder takes the dividend sign, giving truncation toward zero.
  always_comb begin
    prod      = {acc, shreg};
    prod_fix  = res_neg ? -prod : prod;
    quo_fix   = res_neg ? -shreg : shreg;
    rem_fix   = rem_neg ? -acc : acc;
    last_step = (count == CNT_W'(WIDTH - 1));
  end

  muldiv_sequencer_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op_sel    (op_sel),
    .acc       (acc),
    .shreg     (shreg),
    .operand   (operand),
    .acc_next  (step_acc),
    .shreg_next(step_shreg),
    .q_bit     (step_q)
  );

  // Sequencer: IDLE latches magnitudes and signs, the run states iterate
  // WIDTH times, FIX writes HI/LO and FINISH emits the done pulse. A divide
  // by zero skips straight to FINISH so HI/LO are left untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      op_sel   <= OP_MULT;
      acc      <= '0;
      shreg    <= '0;
      operand  <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      dz_pend  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mult_start || div_start) begin
            busy    <= 1'b1;
            count   <= '0;
            acc     <= '0;
            res_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            rem_neg <= op_a[WIDTH-1];
            if (mult_start) begin
              op_sel  <= OP_MULT;
              operand <= mag_a;
              shreg   <= mag_b;
              dz_pend <= 1'b0;
              state   <= ST_MUL_RUN;
            end else begin
              op_sel  <= OP_DIV;
              operand <= mag_b;
              shreg   <= mag_a;
              if (op_b == '0) begin
                dz_pend <= 1'b1;
                state   <= ST_FINISH;
              end else begin
                dz_pend <= 1'b0;
                state   <= ST_DIV_RUN;
              end
            end
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          acc   <= step_acc;
          shreg <= {step_shreg[WIDTH-1:1], step_shreg[0] | step_q};
          count <= count + CNT_W'(1);
          if (last_step) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (op_sel == OP_MULT) begin
            hi_out <= prod_fix[2*WIDTH-1:WIDTH];
            lo_out <= prod_fix[WIDTH-1:0];
          end else begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end
          state <= ST_FINISH;
        end
        ST_FINISH: begin
          done     <= 1'b1;
          div_zero <= dz_pend;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
